// File: rtl/timer_multi_ch_if.sv
// Panel bundle for the multi-channel countdown timer: keypad, start button,
// channel select, entry switch, and the display/LED/done outputs.
interface timer_multi_ch_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              dip_sw_timer;
    logic [CH_W-1:0]   ch_sel;
    logic [9:0]        keypad;
    logic              btn_start;
    logic [7:0]        seg_data;
    logic [7:0]        seg_com;
    logic [7:0]        led;
    logic [NUM_CH-1:0] done;

    modport master (
        output dip_sw_timer, ch_sel, keypad, btn_start,
        input  seg_data, seg_com, led, done
    );

    modport slave (
        input  dip_sw_timer, ch_sel, keypad, btn_start,
        output seg_data, seg_com, led, done
    );
endinterface

// File: rtl/timer_multi_ch.sv
// NUM_CH independent HH:MM:SS countdown channels sharing one keypad,
// one start button and one 8-digit display. Optional: TIMER_MC_RELOAD_EN.
module timer_multi_ch #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int NUM_CH        = 4,
    parameter int BLINK_TICKS   = 500,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    timer_multi_ch_if.slave  bus
);

    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PS_W-1:0] PS_TOP = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [BL_W-1:0] BL_TOP = BL_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } ch_state_e;

    ch_state_e         st_q  [NUM_CH];
    ch_state_e         st_d  [NUM_CH];
    logic [23:0]       val_q [NUM_CH];
    logic [23:0]       val_d [NUM_CH];
    logic [PS_W-1:0]   ps_q  [NUM_CH];
    logic [PS_W-1:0]   ps_d  [NUM_CH];
    logic [BL_W-1:0]   bl_q  [NUM_CH];
    logic [BL_W-1:0]   bl_d  [NUM_CH];
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] led_d;
`ifdef TIMER_MC_RELOAD_EN
    logic [23:0]       pre_q [NUM_CH];
    logic [23:0]       pre_d [NUM_CH];
`endif

    logic [9:0]        key_q;
    logic              btn_q;
    logic              dip_q;
    logic [CH_W-1:0]   chs_q;
    logic [2:0]        ptr_q;
    logic [2:0]        ptr_d;
    logic [2:0]        scan_q;
    logic [7:0]        seg_data_q;
    logic [7:0]        seg_data_d;
    logic [7:0]        seg_com_q;
    logic [7:0]        seg_com_d;

    logic              ch_ok;
    logic              key_ev;
    logic              btn_ev;
    logic              entry;
    logic              start_ev;
    logic [3:0]        key_dig;
    logic [2:0]        ptr_eff;
    logic              dig_ok;
    logic              wr_en;
    logic [NUM_CH-1:0] sel_vec;
    logic [23:0]       sel_val;
    logic [23:0]       nv;

    // Digit k sits at bits [23-4k -: 4]; k=0 is h_ten, k=5 is s_one.
    function automatic logic [23:0] set_digit(
        input logic [23:0] v,
        input logic [2:0]  pos,
        input logic [3:0]  d
    );
        logic [23:0] r;
        r = v;
        case (pos)
            3'd0:    r[23:20] = d;
            3'd1:    r[19:16] = d;
            3'd2:    r[15:12] = d;
            3'd3:    r[11:8]  = d;
            3'd4:    r[7:4]   = d;
            default: r[3:0]   = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] get_digit(
        input logic [23:0] v,
        input logic [2:0]  pos
    );
        logic [3:0] r;
        case (pos)
            3'd0:    r = v[23:20];
            3'd1:    r = v[19:16];
            3'd2:    r = v[15:12];
            3'd3:    r = v[11:8];
            3'd4:    r = v[7:4];
            default: r = v[3:0];
        endcase
        return r;
    endfunction

    // One-second BCD decrement; only ever applied to a nonzero value.
    function automatic logic [23:0] dec_val(input logic [23:0] v);
        logic [3:0] ht, ho, mt, mo, st, so;
        {ht, ho, mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    if (mt != 4'd0) begin
                        mt = mt - 4'd1;
                    end else begin
                        mt = 4'd5;
                        if (ho != 4'd0) begin
                            ho = ho - 4'd1;
                        end else begin
                            ho = 4'd9;
                            ht = ht - 4'd1;
                        end
                    end
                end
            end
        end
        return {ht, ho, mt, mo, st, so};
    endfunction

    function automatic logic [7:0] seg_pat(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0:    r = 8'h3F;
            4'd1:    r = 8'h06;
            4'd2:    r = 8'h5B;
            4'd3:    r = 8'h4F;
            4'd4:    r = 8'h66;
            4'd5:    r = 8'h6D;
            4'd6:    r = 8'h7D;
            4'd7:    r = 8'h07;
            4'd8:    r = 8'h7F;
            4'd9:    r = 8'h6F;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Input events, channel decode and entry pointer next state.
    always_comb begin
        ch_ok    = int'(bus.ch_sel) < NUM_CH;
        key_ev   = $onehot(bus.keypad) && (key_q == 10'd0);
        btn_ev   = bus.btn_start && !btn_q;
        entry    = bus.dip_sw_timer && ch_ok;
        start_ev = btn_ev && !bus.dip_sw_timer && ch_ok;
        key_dig  = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (bus.keypad[k]) key_dig = 4'(k);
        end
        sel_vec = '0;
        sel_val = 24'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_vec[i] = ch_ok && (bus.ch_sel == CH_W'(i));
            if (sel_vec[i]) sel_val = val_q[i];
        end
        if ((bus.ch_sel != chs_q) || (bus.dip_sw_timer && !dip_q)) begin
            ptr_eff = 3'd0;
        end else begin
            ptr_eff = ptr_q;
        end
        dig_ok = !(((ptr_eff == 3'd2) || (ptr_eff == 3'd4))
                   && (key_dig > 4'd5));
        wr_en  = entry && key_ev && dig_ok;
        ptr_d  = ptr_eff;
        if (wr_en) begin
            ptr_d = (ptr_eff == 3'd5) ? 3'd0 : ptr_eff + 3'd1;
        end
    end

    // Per-channel FSM next state, countdown, entry writes and alarm blink.
    always_comb begin
        nv    = 24'd0;
        led_d = led_q;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            val_d[i] = val_q[i];
            ps_d[i]  = ps_q[i];
            bl_d[i]  = bl_q[i];
`ifdef TIMER_MC_RELOAD_EN
            pre_d[i] = pre_q[i];
`endif
            if (entry && sel_vec[i]) begin
                st_d[i] = ST_IDLE;
                ps_d[i] = '0;
                if (wr_en) begin
                    val_d[i] = set_digit(val_q[i], ptr_eff, key_dig);
`ifdef TIMER_MC_RELOAD_EN
                    pre_d[i] = set_digit(val_q[i], ptr_eff, key_dig);
`endif
                end
            end else if (start_ev && sel_vec[i]) begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (val_q[i] != 24'd0) begin
                            st_d[i] = ST_RUN;
                            ps_d[i] = '0;
                        end
                    end
                    ST_RUN:   st_d[i] = ST_PAUSE;
                    ST_PAUSE: st_d[i] = ST_RUN;
                    default: begin
                        st_d[i] = ST_IDLE;
`ifdef TIMER_MC_RELOAD_EN
                        val_d[i] = pre_q[i];
`endif
                    end
                endcase
            end else if (st_q[i] == ST_RUN) begin
                if (ps_q[i] == PS_TOP) begin
                    ps_d[i]  = '0;
                    nv       = dec_val(val_q[i]);
                    val_d[i] = nv;
                    if (nv == 24'd0) st_d[i] = ST_DONE;
                end else begin
                    ps_d[i] = ps_q[i] + 1'b1;
                end
            end
            if ((st_q[i] == ST_DONE) && (st_d[i] == ST_DONE)) begin
                if (bl_q[i] == BL_TOP) begin
                    bl_d[i]  = '0;
                    led_d[i] = !led_q[i];
                end else begin
                    bl_d[i] = bl_q[i] + 1'b1;
                end
            end else begin
                bl_d[i]  = '0;
                led_d[i] = 1'b0;
            end
        end
    end

    // Display pattern for the current scan position.
    always_comb begin
        seg_com_d = ~(8'h80 >> scan_q);
        case (scan_q)
            3'd0:    seg_data_d = seg_pat(4'(bus.ch_sel));
            3'd1:    seg_data_d = 8'h00;
            default: begin
                if (ch_ok) begin
                    seg_data_d = seg_pat(get_digit(sel_val, scan_q - 3'd2));
                end else begin
                    seg_data_d = 8'h00;
                end
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= ST_IDLE;
                val_q[i] <= 24'd0;
                ps_q[i]  <= '0;
                bl_q[i]  <= '0;
`ifdef TIMER_MC_RELOAD_EN
                pre_q[i] <= 24'd0;
`endif
            end
            led_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                val_q[i] <= val_d[i];
                ps_q[i]  <= ps_d[i];
                bl_q[i]  <= bl_d[i];
`ifdef TIMER_MC_RELOAD_EN
                pre_q[i] <= pre_d[i];
`endif
            end
            led_q <= led_d;
        end
    end

    // Input history, entry pointer and display scan registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= 10'd0;
            btn_q      <= 1'b0;
            dip_q      <= 1'b0;
            chs_q      <= '0;
            ptr_q      <= 3'd0;
            scan_q     <= 3'd0;
            seg_data_q <= 8'h00;
            seg_com_q  <= 8'hFF;
        end else begin
            key_q      <= bus.keypad;
            btn_q      <= bus.btn_start;
            dip_q      <= bus.dip_sw_timer;
            chs_q      <= bus.ch_sel;
            ptr_q      <= ptr_d;
            scan_q     <= scan_q + 3'd1;
            seg_data_q <= seg_data_d;
            seg_com_q  <= seg_com_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.seg_data = seg_data_q;
        bus.seg_com  = seg_com_q;
        bus.led      = 8'h00;
        bus.led[NUM_CH-1:0] = led_q;
        bus.done     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.done[i] = (st_q[i] == ST_DONE);
        end
    end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Directed bench for timer_multi_ch: entry table, countdown timing,
// pause/resume, alarm blink, acknowledge and reset.
module tb_timer_multi_ch;

    localparam int TPS = 20;
    localparam int BT  = 7;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    typedef struct {
        logic [9:0]  pat;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [11];

    timer_multi_ch_if #(.NUM_CH(NCH)) bus ();

    timer_multi_ch #(
        .TICKS_PER_SEC (TPS),
        .NUM_CH        (NCH),
        .BLINK_TICKS   (BT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    function automatic logic [47:0] exp_disp(input logic [23:0] v);
        logic [47:0] r;
        logic [3:0]  d;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            d = v[23-4*k -: 4];
            r[47-8*k -: 8] = SEG[d];
        end
        return r;
    endfunction

    task automatic read_disp(output logic [47:0] digs,
                             output logic [7:0] p0);
        logic [7:0] d [8];
        logic [7:0] m;
        for (int k = 0; k < 8; k++) d[k] = 8'hEE;
        repeat (8) begin
            step(1);
            for (int p = 0; p < 8; p++) begin
                m = 8'h80 >> p;
                m = ~m;
                if (bus.seg_com == m) d[p] = bus.seg_data;
            end
        end
        digs = {d[2], d[3], d[4], d[5], d[6], d[7]};
        p0   = d[0];
    endtask

    task automatic press_pat(input logic [9:0] pat);
        bus.keypad = pat;
        step(1);
        bus.keypad = 10'd0;
        step(1);
    endtask

    task automatic press(input logic [3:0] d);
        press_pat(10'd1 << d);
    endtask

    task automatic enter(input int ch, input logic [23:0] v);
        bus.ch_sel = 2'(ch);
        bus.dip_sw_timer = 1'b1;
        step(1);
        for (int k = 0; k < 6; k++) press(v[23-4*k -: 4]);
        bus.dip_sw_timer = 1'b0;
        step(1);
    endtask

    task automatic push(input int ch, output int e);
        bus.ch_sel = 2'(ch);
        bus.btn_start = 1'b1;
        step(1);
        e = cyc;
        bus.btn_start = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int ch, input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.done[ch]) begin
                d = cyc;
                break;
            end
        end
    endtask

    task automatic wait_led(input logic v, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.led[0] == v) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        logic [47:0] digs;
        logic [7:0]  p0;
        logic [23:0] ack_exp;
        int s, d, p, r, t1, t2, s0, s2, d0, d2;

        vecs[0]  = '{10'd1 << 0, 24'h000000};
        vecs[1]  = '{10'd1 << 0, 24'h000000};
        vecs[2]  = '{10'd1 << 7, 24'h000000};
        vecs[3]  = '{10'd1 << 5, 24'h005000};
        vecs[4]  = '{10'd1 << 9, 24'h005900};
        vecs[5]  = '{10'd1 << 8, 24'h005900};
        vecs[6]  = '{10'h003,    24'h005900};
        vecs[7]  = '{10'd1 << 4, 24'h005940};
        vecs[8]  = '{10'd1 << 2, 24'h005942};
        vecs[9]  = '{10'd1 << 1, 24'h105942};
        vecs[10] = '{10'd1 << 3, 24'h135942};

        bus.dip_sw_timer = 1'b0;
        bus.ch_sel       = 2'd0;
        bus.keypad       = 10'd0;
        bus.btn_start    = 1'b0;

        step(3);
        check("rst_seg_com", bus.seg_com, 8'hFF);
        check("rst_seg_data", bus.seg_data, 8'h00);
        check("rst_led", bus.led, 8'h00);
        check("rst_done", bus.done, 4'h0);
        rst = 1'b0;
        step(1);

        enter(0, 24'h000003);
        push(0, s);
        wait_done(0, 4 * TPS, d);
        check("ch0_done_time", d - s, 3 * TPS);
        check("ch0_led_low_at_done", bus.led[0], 1'b0);
        wait_led(1'b1, 3 * BT, t1);
        check("ch0_led_rise", t1 - d, BT);
        wait_led(1'b0, 3 * BT, t2);
        check("ch0_led_fall", t2 - t1, BT);

        push(0, s);
        check("ack_done", bus.done[0], 1'b0);
        check("ack_led", bus.led[0], 1'b0);
`ifdef TIMER_MC_RELOAD_EN
        ack_exp = 24'h000003;
`else
        ack_exp = 24'h000000;
`endif
        read_disp(digs, p0);
        check("ack_digits", digs, exp_disp(ack_exp));

        bus.ch_sel = 2'd1;
        bus.dip_sw_timer = 1'b1;
        step(1);
        for (int i = 0; i < 11; i++) begin
            press_pat(vecs[i].pat);
            read_disp(digs, p0);
            check($sformatf("entry_vec%0d", i), digs, exp_disp(vecs[i].exp));
        end
        bus.dip_sw_timer = 1'b0;
        step(1);

        enter(2, 24'h010000);
        push(2, s);
        step(TPS - 1);
        read_disp(digs, p0);
        check("disp_005959", digs, exp_disp(24'h005959));
        check("disp_ch_digit", p0, SEG[2]);
        push(2, p);

        enter(0, 24'h000002);
        push(0, s);
        step(6);
        push(0, p);
        step(4998);
        push(0, r);
        wait_done(0, 3 * TPS, d);
        check("pause_total", d - s, 2 * TPS + (r - p + 1));

        enter(2, 24'h000001);
        enter(0, 24'h000003);
        push(0, s0);
        push(2, s2);
        enter(1, 24'h123456);
        d0 = -1;
        d2 = -1;
        for (int i = 0; i < 5 * TPS; i++) begin
            step(1);
            if (bus.done[0] && d0 < 0) d0 = cyc;
            if (bus.done[2] && d2 < 0) d2 = cyc;
        end
        check("multi_ch2_time", d2 - s2, TPS);
        check("multi_ch0_time", d0 - s0, 3 * TPS);
        bus.ch_sel = 2'd1;
        read_disp(digs, p0);
        check("multi_ch1_digits", digs, exp_disp(24'h123456));

        push(3, s);
        step(2 * TPS);
        check("zero_start_done", bus.done[3], 1'b0);
        read_disp(digs, p0);
        check("zero_start_digits", digs, exp_disp(24'h000000));

        bus.ch_sel = 2'd3;
        bus.dip_sw_timer = 1'b1;
        step(1);
        press(4'd1);
        press(4'd2);
        bus.ch_sel = 2'd2;
        step(1);
        bus.ch_sel = 2'd3;
        step(1);
        press(4'd9);
        bus.btn_start = 1'b1;
        step(1);
        bus.btn_start = 1'b0;
        step(1);
        bus.dip_sw_timer = 1'b0;
        step(2 * TPS);
        read_disp(digs, p0);
        check("ptr_reset_btn_ignored", digs, exp_disp(24'h920000));
        check("ptr_ch_digit", p0, SEG[3]);

        enter(1, 24'h000005);
        push(1, s);
        step(5);
        rst = 1'b1;
        step(1);
        check("midrst_done", bus.done, 4'h0);
        check("midrst_seg_com", bus.seg_com, 8'hFF);
        rst = 1'b0;
        step(TPS + 2);
        check("midrst_done_later", bus.done, 4'h0);
        read_disp(digs, p0);
        check("midrst_digits", digs, exp_disp(24'h000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
